// File: rtl/hazard_pkg.sv
// hazard_pkg: forwarding-select encodings, the "operand not read" Tuse value
// and the shadow-scoreboard entry shared by hazard_unit and its counter.
package hazard_pkg;
   localparam int SB_AW = 5;
   localparam int SB_TW = 2;
   localparam logic [1:0] FWD_RF = 2'd0;
   localparam logic [1:0] FWD_E  = 2'd1;
   localparam logic [1:0] FWD_M  = 2'd2;
   localparam logic [1:0] FWD_W  = 2'd3;
   localparam logic [SB_TW-1:0] TUSE_NONE = '1;
   typedef struct packed {
      logic [SB_AW-1:0] a3;
      logic [SB_TW-1:0] tnew;
      logic             md_start;
      logic             md_div;
   } sb_entry_t;
   // Stages beyond W have no bypass path of their own, so they map onto W.
   function automatic logic [1:0] fwd_enc(input int k);
      return k == 0 ? FWD_E : k == 1 ? FWD_M : FWD_W;
   endfunction
endpackage

// File: rtl/md_busy_ctr.sv
// md_busy_ctr: multiply/divide occupancy counter, loaded when an MDU start
// reaches E while the unit is idle.
module md_busy_ctr #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic md_start_i,
   input  logic md_div_i,
   output logic md_busy_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // A start arriving while busy is dropped; the running count carries on.
   always_comb cnt_d = (md_start_i && cnt_q == '0) ? (md_div_i ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES))
                     : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);
   always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
   assign md_busy_o = cnt_q != '0 || md_start_i;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: shadow scoreboard of in-flight destinations beside the D stage,
// producing the global stall and D-stage forwarding selects.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW     = SB_AW,
   parameter int TW         = SB_TW,
   parameter int DEPTH      = 3,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic [TW-1:0]     d_tuse_rs,
   input  logic [TW-1:0]     d_tuse_rt,
   input  logic [REG_AW-1:0] d_a3,
   input  logic [TW-1:0]     d_tnew,
   input  logic              d_md_use,
   input  logic              d_md_start,
   input  logic              d_md_div,
   output logic              stall,
   output logic              md_busy,
   output logic [1:0]        fwd_rs_d,
   output logic [1:0]        fwd_rt_d,
   output logic [31:0]       stall_cnt
);
   sb_entry_t        sh_q [DEPTH];
   sb_entry_t        sh_d [DEPTH];
   logic [DEPTH-1:0] m_rs, m_rt;
   logic             rs_live, rt_live, hz_rs, hz_rt;
   logic [31:0]      stall_cnt_q, stall_cnt_d;
   assign rs_live = d_rs != '0 && d_tuse_rs != TUSE_NONE;
   assign rt_live = d_rt != '0 && d_tuse_rt != TUSE_NONE;
   genvar k;
   for (k = 0; k < DEPTH; k++) begin : g_sh
      assign m_rs[k] = rs_live && sh_q[k].a3 == d_rs;
      assign m_rt[k] = rt_live && sh_q[k].a3 == d_rt;
      if (k == 0) begin : g_head
         assign sh_d[k] = stall ? '0 : {d_a3, d_tnew, d_md_start, d_md_div};
      end else begin : g_tail
         assign sh_d[k] = {sh_q[k-1].a3,
                           sh_q[k-1].tnew == '0 ? sh_q[k-1].tnew : sh_q[k-1].tnew - SB_TW'(1),
                           sh_q[k-1].md_start, sh_q[k-1].md_div};
      end
   end
   // Oldest first so the youngest matching stage has the final say.
   always_comb begin
      hz_rs    = 1'b0;
      hz_rt    = 1'b0;
      fwd_rs_d = FWD_RF;
      fwd_rt_d = FWD_RF;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m_rs[i]) begin
            hz_rs    = sh_q[i].tnew > d_tuse_rs;
            fwd_rs_d = sh_q[i].tnew == '0 ? fwd_enc(i) : FWD_RF;
         end
         if (m_rt[i]) begin
            hz_rt    = sh_q[i].tnew > d_tuse_rt;
            fwd_rt_d = sh_q[i].tnew == '0 ? fwd_enc(i) : FWD_RF;
         end
      end
   end
   md_busy_ctr #(
      .MUL_CYCLES(MUL_CYCLES),
      .DIV_CYCLES(DIV_CYCLES),
      .CNT_W     (CNT_W)
   ) u_md (
      .clk       (clk),
      .reset     (reset),
      .md_start_i(sh_q[0].md_start),
      .md_div_i  (sh_q[0].md_div),
      .md_busy_o (md_busy)
   );
   assign stall       = hz_rs || hz_rt || (d_md_use && md_busy);
   assign stall_cnt_d = (stall && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
   assign stall_cnt   = stall_cnt_q;
   always_ff @(posedge clk) begin
      if (!reset) begin
         sh_q        <= '{default: '0};
         stall_cnt_q <= '0;
      end else begin
         sh_q        <= sh_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed D-stage sequences with hand-computed responses,
// queued by the driver and checked by a negedge monitor.
module tb_hazard_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  d_rs, d_rt, d_a3;
   logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
   logic        d_md_use, d_md_start, d_md_div;
   logic        stall, md_busy;
   logic [1:0]  fwd_rs_d, fwd_rt_d;
   logic [31:0] stall_cnt;

   typedef struct {
      string       name;
      logic        stall;
      logic [1:0]  frs;
      logic [1:0]  frt;
      logic        busy;
      logic [31:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t em;
   int   vecs = 0;
   int   errs = 0;

   hazard_unit dut (
      .clk       (clk),
      .reset     (reset),
      .d_rs      (d_rs),
      .d_rt      (d_rt),
      .d_tuse_rs (d_tuse_rs),
      .d_tuse_rt (d_tuse_rt),
      .d_a3      (d_a3),
      .d_tnew    (d_tnew),
      .d_md_use  (d_md_use),
      .d_md_start(d_md_start),
      .d_md_div  (d_md_div),
      .stall     (stall),
      .md_busy   (md_busy),
      .fwd_rs_d  (fwd_rs_d),
      .fwd_rt_d  (fwd_rt_d),
      .stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string nm, input logic rn,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] trs, input logic [1:0] trt,
                      input logic [4:0] a3, input logic [1:0] tn,
                      input logic mu, input logic ms, input logic md,
                      input logic es, input logic [1:0] efs, input logic [1:0] eft,
                      input logic eb, input int ec);
      exp_t x;
      @(posedge clk);
      #1;
      reset = rn; d_rs = rs; d_rt = rt; d_tuse_rs = trs; d_tuse_rt = trt;
      d_a3 = a3; d_tnew = tn; d_md_use = mu; d_md_start = ms; d_md_div = md;
      x.name = nm; x.stall = es; x.frs = efs; x.frt = eft; x.busy = eb; x.cnt = 32'(ec);
      q.push_back(x);
   endtask

   always @(negedge clk) begin
      if (q.size() != 0) begin
         em = q.pop_front();
         vecs++;
         if (stall !== em.stall) begin
            errs++;
            $display("FAIL %s stall: got %0b want %0b", em.name, stall, em.stall);
         end
         if (fwd_rs_d !== em.frs) begin
            errs++;
            $display("FAIL %s fwd_rs_d: got %0d want %0d", em.name, fwd_rs_d, em.frs);
         end
         if (fwd_rt_d !== em.frt) begin
            errs++;
            $display("FAIL %s fwd_rt_d: got %0d want %0d", em.name, fwd_rt_d, em.frt);
         end
         if (md_busy !== em.busy) begin
            errs++;
            $display("FAIL %s md_busy: got %0b want %0b", em.name, md_busy, em.busy);
         end
         if (stall_cnt !== em.cnt) begin
            errs++;
            $display("FAIL %s stall_cnt: got %0d want %0d", em.name, stall_cnt, em.cnt);
         end
      end
   end

   initial begin
      reset = 1'b0; d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
      d_a3 = '0; d_tnew = '0; d_md_use = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
      repeat (2) @(posedge clk);
      //    name               rn rs rt trs trt a3 tn mu ms md  st frs frt bsy cnt
      cyc("reset_any_d",       0, 5, 6, 0, 0, 7, 2, 1, 0, 0,  0, 0, 0, 0, 0);
      cyc("lw",                1, 0, 0, 3, 3, 1, 2, 0, 0, 0,  0, 0, 0, 0, 0);
      cyc("lw_use_stall",      1, 1, 0, 1, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0);
      cyc("lw_use_go",         1, 1, 0, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
      cyc("addu",              1, 0, 0, 3, 3, 3, 1, 0, 0, 0,  0, 0, 0, 0, 1);
      cyc("beq_stall",         1, 3, 3, 0, 3, 0, 0, 0, 0, 0,  1, 0, 0, 0, 1);
      cyc("beq_fwd_m",         1, 3, 3, 0, 3, 0, 0, 0, 0, 0,  0, 2, 0, 0, 2);
      cyc("zero_dst_w_fwd",    1, 0, 3, 0, 0, 0, 2, 0, 0, 0,  0, 0, 3, 0, 2);
      cyc("zero_dst_use",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2);
      cyc("prod_old",          1, 0, 0, 3, 3, 2, 1, 0, 0, 0,  0, 0, 0, 0, 2);
      cyc("prod_young",        1, 0, 0, 3, 3, 2, 1, 0, 0, 0,  0, 0, 0, 0, 2);
      cyc("youngest_stall",    1, 2, 2, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 2);
      cyc("youngest_fwd",      1, 2, 2, 0, 1, 0, 0, 0, 0, 0,  0, 2, 2, 0, 3);
      cyc("nop",               1, 0, 0, 3, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3);
      cyc("mult",              1, 0, 0, 3, 3, 0, 0, 1, 1, 0,  0, 0, 0, 0, 3);
      cyc("mflo_start",        1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 3);
      for (int n = 0; n < 5; n++)
         cyc("mul_busy",       1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 4 + n);
      cyc("mflo_go",           1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  0, 0, 0, 0, 9);
      cyc("div",               1, 0, 0, 3, 3, 0, 0, 1, 1, 1,  0, 0, 0, 0, 9);
      cyc("mfhi_start",        1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 9);
      for (int n = 0; n < 10; n++)
         cyc("div_busy",       1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 10 + n);
      cyc("mfhi_go",           1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  0, 0, 0, 0, 20);
      cyc("div2",              1, 0, 0, 3, 3, 0, 0, 1, 1, 1,  0, 0, 0, 0, 20);
      cyc("mflo2_start",       1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 20);
      for (int n = 0; n < 2; n++)
         cyc("div2_busy",      1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 21 + n);
      cyc("reset_mid_div",     0, 0, 0, 3, 3, 0, 0, 1, 0, 0,  1, 0, 0, 1, 23);
      cyc("mflo_after_rst",    1, 0, 0, 3, 3, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
      @(posedge clk);
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain: %0d vectors unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard-detection and forwarding-select unit for the five-stage MIPS pipeline. It succeeds the combinational Tuse/Tnew stall logic with a shadow scoreboard of configurable depth. The scoreboard tracks each in-flight destination register and its remaining Tnew, and the unit adds a multi-cycle multiply/divide busy counter that stalls MDU-touching instructions. It sits beside the D stage, consumes pre-decoded D-stage fields, and drives the global stall plus D-stage forwarding selects.

## Interface
- REG_AW, 5, register address width
- TW, 2, Tnew/Tuse width; all-ones Tuse means "operand not read"
- DEPTH, 3, tracked stages after D (E, M, W)
- MUL_CYCLES, 5, mult busy cycles
- DIV_CYCLES, 10, div busy cycles
- CNT_W, 4, busy-counter width; must hold max(MUL_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- d_rs, d_rt  in  REG_AW  D-stage source registers
- d_tuse_rs, d_tuse_rt  in  TW  cycles until operand is needed, counted from D
- d_a3  in  REG_AW  D-stage destination; 0 means no write
- d_tnew  in  TW  cycles after entering E until the result is forwardable
- d_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- d_md_start, d_md_div  in  1  D instruction starts the MDU; div when d_md_div=1
- stall  out  1  freeze PC and F/D, bubble into E
- md_busy  out  1  MDU occupied
- fwd_rs_d, fwd_rt_d  out  2  0=RF, 1=E, 2=M, 3=W
- stall_cnt  out  32  saturating count of stall cycles

## Operation
- Shadow entry per stage k (0=E … DEPTH-1): a3, tnew, md_start, md_div.
- Each clk:
  - If stall=1, stage0 loads a bubble: all fields 0.
  - Otherwise stage0 loads the D fields.
  - Stage k loads stage k-1 with tnew decremented, saturating at 0.
  - The last stage's contents are dropped.
- Operand hazard, per rs and rt:
  - Ignored when the address is 0 or Tuse is all-ones.
  - Match = youngest stage whose a3 equals the address.
  - Stall if match.tnew > Tuse.
  - Older matches are never considered.
- Forward select: if the youngest match has tnew==0, sel = k+1; else sel = 0.
- MDU counter:
  - When stage0.md_start=1 and cnt==0, cnt loads DIV_CYCLES if md_div else MUL_CYCLES.
  - Otherwise cnt decrements to 0.
  - md_busy = (cnt!=0) | stage0.md_start.
- stall = hazard_rs | hazard_rt | (d_md_use & md_busy).
- stall_cnt increments on each stalled cycle and saturates at 2^32-1.

## Timing
- stall, fwd_*, md_busy: combinational from D inputs and registered state, in the same cycle.
- Reset (reset=0 at a clk edge):
  - All shadow entries are cleared to 0, cnt=0, stall_cnt=0.
  - Following the edge, md_busy=0, fwd_*=0, and stall=0 for any D input.
  - Reset mid-divide aborts busy immediately.
- A stalled instruction re-evaluates every cycle. Its bubble cannot re-trigger the MDU.
- md_start while cnt!=0 cannot occur, because MDU instructions stall. If forced, the load is ignored and cnt keeps counting down.
- Destination 0 never creates a hazard and never forwards.
- DEPTH=1 tracks E only. Older producers are assumed to be resolved by the register file's write-through.

## Structure
- Package hazard_pkg holds the forwarding-select encodings (FWD_RF/E/M/W), the TUSE_NONE constant, and the shadow-entry struct.
- One sub-module, md_busy_ctr, contains the MDU counter and the md_busy logic.
- The shadow array and match priority use a generate loop over DEPTH.

## Test plan
- lw-use: D=(a3=1, tnew=2), then add with rs=1, tuse=1 → stall=1 for exactly 1 cycle, then stall=0.
- beq after addu: addu a3=3, tnew=1; beq rs=3, tuse=0 → 1 stall cycle, then fwd_rs_d=2.
- $0 destination: a3=0, tnew=2, consumer rs=0, tuse=0 → stall=0, fwd_rs_d=0.
- mult then mflo, MUL_CYCLES=5 → stall high 6 cycles, md_busy falls after cycle 6, stall_cnt=6. The same sequence with div at DIV_CYCLES=10 gives 11 cycles.
- Youngest priority: E entry a3=2, tnew=1; M entry a3=2, tnew=0; consumer tuse=0 → stall=1. Next cycle → fwd=2.
- Reset mid-div: reset=0 for 1 cycle at busy cycle 4 → md_busy=0, stall_cnt=0, and a following mflo has no stall.
